// File: rtl/hazard_pkg.sv
// Shared constants for the hazard controller: opcodes, decoder
// Ctrl bundle bit positions, FSM states and source-use helpers.
package hazard_pkg;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam int REGWRITE = 0;
  localparam int MEM2REG  = 1;
  localparam int MEMREAD  = 2;
  localparam int MEMWRITE = 3;
  localparam int ALUOP_LO = 4;
  localparam int ALUOP_HI = 5;
  localparam int ALUSRC   = 6;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_STALL,
    ST_FREEZE
  } state_e;

  function automatic logic uses_rs1(
    input logic [6:0] op
  );
    return (op == OP_RTYPE) || (op == OP_STORE) ||
           (op == OP_BRANCH) || (op == OP_ITYPE) ||
           (op == OP_LOAD);
  endfunction

  function automatic logic uses_rs2(
    input logic [6:0] op
  );
    return (op == OP_RTYPE) || (op == OP_STORE) ||
           (op == OP_BRANCH);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with synchronous clear.
// Holds at all-ones once full.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller: load-use / branch-operand stalls, dmem freeze,
// watchdog. HAZARD_CTRL_PERF_EN adds saturating perf counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MAX_WAIT = 64,
  parameter int CNT_W    = 32
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [6:0] ifid_op_i,
  input  logic [4:0] ifid_rs1_i,
  input  logic [4:0] ifid_rs2_i,
  input  logic       idex_memread_i,
  input  logic       idex_regwrite_i,
  input  logic [4:0] idex_rd_i,
  input  logic       exmem_memread_i,
  input  logic [4:0] exmem_rd_i,
  input  logic       branch_taken_i,
  input  logic       dmem_stall_i,
  output logic       noop_o,
  output logic       pc_write_o,
  output logic       ifid_write_o,
  output logic       ifid_flush_o,
  output logic       freeze_o,
  output logic       timeout_o
`ifdef HAZARD_CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0] bubble_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o,
  output logic [CNT_W-1:0] freeze_cnt_o
`endif
);

  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam logic [WW-1:0] WMAX = WW'(MAX_WAIT);

  state_e state_q, state_d;
  state_e ret_q, ret_d, eff;
  logic [1:0] bub_q, bub_d;
  logic [WW-1:0] wait_q, wait_d;
  logic tmo_q, tmo_d;

  logic u1, u2, beq;
  logic hit_ex, hit_mem;
  logic [1:0] need;

  always_comb begin
    u1  = uses_rs1(ifid_op_i) && (ifid_rs1_i != 5'd0);
    u2  = uses_rs2(ifid_op_i) && (ifid_rs2_i != 5'd0);
    beq = (ifid_op_i == OP_BRANCH);
    hit_ex  = (u1 && (ifid_rs1_i == idex_rd_i)) ||
              (u2 && (ifid_rs2_i == idex_rd_i));
    hit_mem = (u1 && (ifid_rs1_i == exmem_rd_i)) ||
              (u2 && (ifid_rs2_i == exmem_rd_i));
    need = 2'd0;
    if (beq && hit_ex && idex_memread_i) begin
      need = 2'd2;
    end else if (hit_ex && idex_memread_i) begin
      need = 2'd1;
    end else if (beq && hit_ex && idex_regwrite_i) begin
      need = 2'd1;
    end else if (beq && hit_mem && exmem_memread_i) begin
      need = 2'd1;
    end
  end

  always_comb begin
    state_d      = state_q;
    ret_d        = ret_q;
    bub_d        = bub_q;
    noop_o       = 1'b0;
    pc_write_o   = 1'b1;
    ifid_write_o = 1'b1;
    ifid_flush_o = 1'b0;
    freeze_o     = 1'b0;
    // a released freeze behaves exactly like the state it interrupted
    eff = (state_q == ST_FREEZE) ? ret_q : state_q;
    if (dmem_stall_i) begin
      freeze_o     = 1'b1;
      pc_write_o   = 1'b0;
      ifid_write_o = 1'b0;
      state_d      = ST_FREEZE;
      if (state_q != ST_FREEZE) begin
        ret_d = state_q;
      end
    end else if (eff == ST_STALL) begin
      noop_o       = 1'b1;
      pc_write_o   = 1'b0;
      ifid_write_o = 1'b0;
      bub_d   = (bub_q == 2'd0) ? 2'd0 : bub_q - 2'd1;
      state_d = (bub_q <= 2'd1) ? ST_RUN : ST_STALL;
    end else begin
      state_d = ST_RUN;
      unique case (need)
        2'd2: begin
          noop_o       = 1'b1;
          pc_write_o   = 1'b0;
          ifid_write_o = 1'b0;
          state_d      = ST_STALL;
          bub_d        = 2'd1;
        end
        2'd1: begin
          noop_o       = 1'b1;
          pc_write_o   = 1'b0;
          ifid_write_o = 1'b0;
        end
        default: begin
          ifid_flush_o = branch_taken_i;
        end
      endcase
    end
    if (rst_i) begin
      noop_o       = 1'b1;
      pc_write_o   = 1'b0;
      ifid_write_o = 1'b0;
      ifid_flush_o = 1'b1;
      freeze_o     = 1'b0;
    end
  end

  always_comb begin
    wait_d = '0;
    if (dmem_stall_i) begin
      wait_d = (wait_q == WMAX) ? wait_q : wait_q + 1'b1;
    end
    tmo_d = tmo_q || (wait_d == WMAX);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_RUN;
      ret_q   <= ST_RUN;
      bub_q   <= 2'd0;
      wait_q  <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      bub_q   <= bub_d;
      wait_q  <= wait_d;
      tmo_q   <= tmo_d;
    end
  end

  assign timeout_o = tmo_q;

`ifdef HAZARD_CTRL_PERF_EN
  sat_counter #(.W(CNT_W)) u_bub_cnt (
    .clk_i (clk_i),
    .clr_i (rst_i),
    .inc_i (noop_o),
    .cnt_o (bubble_cnt_o)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk_i (clk_i),
    .clr_i (rst_i),
    .inc_i (ifid_flush_o),
    .cnt_o (flush_cnt_o)
  );

  sat_counter #(.W(CNT_W)) u_frz_cnt (
    .clk_i (clk_i),
    .clr_i (rst_i),
    .inc_i (freeze_o),
    .cnt_o (freeze_cnt_o)
  );
`else
  logic [CNT_W-1:0] perf_unused;
  assign perf_unused = '0;
`endif

endmodule
